pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush sequencer for the five-stage RV32I pipeline. It merges the load-use stall request from the hazard detector, instruction- and data-memory wait conditions, and the EX-stage branch-mispredict flush. From these it drives every pipeline-register write enable, the IF/ID and ID/EX flush strobes, and the ID control-mux select. It sits beside the hazard detector in the top-level datapath and is the only block that gates stage advancement.

## Interface
- `CNT_W`, default 32: width of each performance counter.
- `clk` input 1: pipeline clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ld_use_stall_i` input 1: load-use hazard from the hazard detector.
- `imem_req_i` input 1: IF has a fetch outstanding this cycle.
- `imem_resp_i` input 1: fetch completes this cycle.
- `dmem_req_i` input 1: MEM has a load or store outstanding.
- `dmem_resp_i` input 1: data access completes this cycle.
- `br_mispredict_i` input 1: EX resolved a mispredicted or taken redirect. Held level while EX holds the branch.
- `IF_PC_write_o` output 1: PC load enable.
- `IF_ID_write_o`, `ID_EX_write_o`, `EX_MEM_write_o`, `MEM_WB_write_o` output 1 each: stage-register load enables.
- `IF_ID_flush_o`, `ID_EX_flush_o` output 1 each: load a bubble into the register on this edge. Only meaningful when the matching write is 1.
- `ID_controlmux_sel_o` output `controlmux::controlmux_sel_t`: `norm` or `zero`.
- `state_o` output `pipe_ctrl_state_t`: current wait state, for debug and verification.
- `stall_cycles_o`, `flush_count_o`, `ld_use_count_o` output `CNT_W`: present only with the perf macro.

## Operation
- **Wait terms.**
  - `i_wait = imem_req_i & ~imem_resp_i & ~i_done_q`
  - `d_wait = dmem_req_i & ~dmem_resp_i & ~d_done_q`
  - `freeze = i_wait | d_wait`
- **Done flags.**
  - `i_done_q` sets on `imem_resp_i & freeze`. `d_done_q` sets on `dmem_resp_i & freeze`.
  - Both clear on any cycle with `~freeze`, i.e. when the pipeline advances.
  - Purpose: a response that arrives while the other memory is still stalling is remembered and not waited on again.
- **State register.** States are RUN, WAIT_I, WAIT_D and WAIT_ID.
  - Next state is a pure function of `{i_wait, d_wait}`: 00→RUN, 10→WAIT_I, 01→WAIT_D, 11→WAIT_ID.
  - Any state may go to any state in one cycle.
- **Output priority (highest first):**
  1. `freeze`: all five write enables 0, both flushes 0, mux `norm`. Mispredict and load-use are ignored; they persist because EX/ID are held.
  2. `br_mispredict_i`: all writes 1, `IF_ID_flush_o = ID_EX_flush_o = 1`, mux `zero`. Load-use is ignored because the consumer is squashed.
  3. `ld_use_stall_i`: `IF_PC_write_o = IF_ID_write_o = 0`, `ID_EX_write_o = EX_MEM_write_o = MEM_WB_write_o = 1`, mux `zero`, no flushes.
  4. Otherwise: all writes 1, flushes 0, mux `norm`.
- **Combinational paths.** Outputs are combinational from the inputs and `*_done_q`. There are no combinational loops: memory responses must not depend on the write enables in the same cycle.

## Timing
- **Reset (async assert, sync deassert at the top level).**
  - `state = RUN`, `i_done_q = d_done_q = 0`, counters 0.
  - While `rst_n = 0`, outputs read with all inputs 0: all writes 1, flushes 0, mux `norm`.
  - Reset mid-wait discards the done flags; the memories re-present their requests.
- **Latency.** Zero-cycle decision. A stall costs exactly the cycles from `req` to `resp`. A load-use stall costs exactly one bubble, because the hazard detector deasserts next cycle.
- **Simultaneous `imem_resp_i` and `dmem_resp_i` while both waiting:** advance the same cycle, no flags set.
- **`resp` without `req`:** ignored, no flag set.
- **Done flag held across many cycles:** stays set until the advance cycle.
- **Mispredict arriving on the cycle `freeze` drops:** flush is applied on that edge.

## Configuration
- **`PIPE_CTRL_PERF_EN` defined:** three `CNT_W` saturating counters are compiled in and their outputs exist.
  - `stall_cycles_o` counts `freeze` cycles.
  - `flush_count_o` counts cycles with priority-2 active.
  - `ld_use_count_o` counts cycles with priority-3 active.
  - Each holds at all-ones.
- **Not defined:** no counter logic and no counter ports; all other behaviour is identical.

## Structure
- **`rv32i_types` package:**
  - `pipe_ctrl_state_t` enum (RUN, WAIT_I, WAIT_D, WAIT_ID).
  - Reuses the existing `controlmux::controlmux_sel_t`.
- **Sub-module `sat_counter #(W)`:** enable, clear, saturating count. Instantiated three times under the macro.

## Test plan
- **Reset:** drive `rst_n = 0` with `imem_req_i = 1` → `state_o = RUN`, writes all 1, counters 0. After deassert, with `imem_resp_i = 0` → all writes 0, `state_o = WAIT_I` next cycle.
- **Overlapping waits:**
  - Stimulus: `dmem_req_i` for 5 cycles, `dmem_resp_i` on cycle 5. `imem_req_i` 1 throughout, `imem_resp_i` pulse on cycle 2.
  - Required: `state_o` WAIT_ID→WAIT_D after cycle 2. Frozen for cycles 1–4, advance on cycle 5, `i_done_q` cleared. With perf on, `stall_cycles_o = 4`.
- **Load-use, no memory stall:** `ld_use_stall_i = 1` for one cycle → PC and IF/ID writes 0, `ID_controlmux_sel_o = zero`, EX/MEM/WB writes 1. `ld_use_count_o = 1`.
- **Mispredict with load-use in the same cycle:** all writes 1, both flushes 1, mux `zero`. `flush_count_o = 1`, `ld_use_count_o = 0`.
- **Mispredict during a 3-cycle D wait:** no flush until `dmem_resp_i`; flush on the advance cycle only.
- **Saturation (`CNT_W = 4`, perf on):** 20 freeze cycles → `stall_cycles_o = 15`.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: ID control-mux select
// and the sequencer's wait-state encoding.
package controlmux;
  typedef enum logic {
    norm = 1'b0,
    zero = 1'b1
  } controlmux_sel_t;
endpackage

package rv32i_types;
  typedef enum logic [1:0] {
    RUN     = 2'b00,
    WAIT_I  = 2'b01,
    WAIT_D  = 2'b10,
    WAIT_ID = 2'b11
  } pipe_ctrl_state_t;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/memory-status inputs and stage-control outputs of pipeline_ctrl.
// The datapath side drives through master; the sequencer uses slave.
interface pipeline_ctrl_if;
  import rv32i_types::*;
  import controlmux::*;

  logic             ld_use_stall_i;
  logic             imem_req_i;
  logic             imem_resp_i;
  logic             dmem_req_i;
  logic             dmem_resp_i;
  logic             br_mispredict_i;
  logic             IF_PC_write_o;
  logic             IF_ID_write_o;
  logic             ID_EX_write_o;
  logic             EX_MEM_write_o;
  logic             MEM_WB_write_o;
  logic             IF_ID_flush_o;
  logic             ID_EX_flush_o;
  controlmux_sel_t  ID_controlmux_sel_o;
  pipe_ctrl_state_t state_o;

  modport master (
    output ld_use_stall_i, imem_req_i, imem_resp_i, dmem_req_i, dmem_resp_i, br_mispredict_i,
    input  IF_PC_write_o, IF_ID_write_o, ID_EX_write_o, EX_MEM_write_o, MEM_WB_write_o,
    input  IF_ID_flush_o, ID_EX_flush_o, ID_controlmux_sel_o, state_o
  );

  modport slave (
    input  ld_use_stall_i, imem_req_i, imem_resp_i, dmem_req_i, dmem_resp_i, br_mispredict_i,
    output IF_PC_write_o, IF_ID_write_o, ID_EX_write_o, EX_MEM_write_o, MEM_WB_write_o,
    output IF_ID_flush_o, ID_EX_flush_o, ID_controlmux_sel_o, state_o
  );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  // count enabled cycles, stopping at the maximum value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {W{1'b0}};
    end else if (i_en && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: memory waits freeze every
// stage, then mispredict flush, then load-use bubble. Perf counters: PIPE_CTRL_PERF_EN.
module pipeline_ctrl
  import rv32i_types::*;
  import controlmux::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  pipeline_ctrl_if.slave   bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o,
  output logic [CNT_W-1:0] ld_use_count_o
`endif
);
  logic             r_i_done;
  logic             r_d_done;
  pipe_ctrl_state_t r_state;
  pipe_ctrl_state_t w_state_nxt;
  logic             w_i_wait;
  logic             w_d_wait;
  logic             w_freeze;

  assign w_i_wait = bus.imem_req_i & ~bus.imem_resp_i & ~r_i_done;
  assign w_d_wait = bus.dmem_req_i & ~bus.dmem_resp_i & ~r_d_done;
  // reset forces the pipeline to advance so outputs read as a plain run cycle
  assign w_freeze = rst_n & (w_i_wait | w_d_wait);

  // wait state is a direct encoding of which memories are stalling
  always_comb begin
    w_state_nxt = RUN;
    case ({w_i_wait, w_d_wait})
      2'b00:   w_state_nxt = RUN;
      2'b10:   w_state_nxt = WAIT_I;
      2'b01:   w_state_nxt = WAIT_D;
      2'b11:   w_state_nxt = WAIT_ID;
      default: w_state_nxt = RUN;
    endcase
  end

  // state register and done flags; a response during a freeze is remembered until advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
    end else if (w_freeze) begin
      r_state  <= w_state_nxt;
      r_i_done <= r_i_done | (bus.imem_resp_i & bus.imem_req_i);
      r_d_done <= r_d_done | (bus.dmem_resp_i & bus.dmem_req_i);
    end else begin
      r_state  <= w_state_nxt;
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
    end
  end

  assign bus.state_o = r_state;

  // priority: freeze, mispredict flush, load-use bubble, normal advance
  always_comb begin
    bus.IF_PC_write_o       = 1'b1;
    bus.IF_ID_write_o       = 1'b1;
    bus.ID_EX_write_o       = 1'b1;
    bus.EX_MEM_write_o      = 1'b1;
    bus.MEM_WB_write_o      = 1'b1;
    bus.IF_ID_flush_o       = 1'b0;
    bus.ID_EX_flush_o       = 1'b0;
    bus.ID_controlmux_sel_o = norm;
    if (!rst_n) begin
      bus.ID_controlmux_sel_o = norm;
    end else if (w_freeze) begin
      bus.IF_PC_write_o  = 1'b0;
      bus.IF_ID_write_o  = 1'b0;
      bus.ID_EX_write_o  = 1'b0;
      bus.EX_MEM_write_o = 1'b0;
      bus.MEM_WB_write_o = 1'b0;
    end else if (bus.br_mispredict_i) begin
      bus.IF_ID_flush_o       = 1'b1;
      bus.ID_EX_flush_o       = 1'b1;
      bus.ID_controlmux_sel_o = zero;
    end else if (bus.ld_use_stall_i) begin
      bus.IF_PC_write_o       = 1'b0;
      bus.IF_ID_write_o       = 1'b0;
      bus.ID_controlmux_sel_o = zero;
    end else begin
      bus.ID_controlmux_sel_o = norm;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic w_flush_act;
  logic w_ld_use_act;

  assign w_flush_act  = rst_n & ~w_freeze & bus.br_mispredict_i;
  assign w_ld_use_act = rst_n & ~w_freeze & ~bus.br_mispredict_i & bus.ld_use_stall_i;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .i_en(w_freeze), .i_clr(1'b0), .o_cnt(stall_cycles_o)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .i_en(w_flush_act), .i_clr(1'b0), .o_cnt(flush_count_o)
  );
  sat_counter #(.W(CNT_W)) u_ld_use_cnt (
    .clk(clk), .rst_n(rst_n), .i_en(w_ld_use_act), .i_clr(1'b0), .o_cnt(ld_use_count_o)
  );
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_pipeline_ctrl;
  import rv32i_types::*;
  import controlmux::*;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_ctrl_if bus();
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_c, flush_c, ld_c;
`endif

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles_o(stall_c),
    .flush_count_o(flush_c),
    .ld_use_count_o(ld_c)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // model: has the outstanding fetch / data access already been served during this stall
  bit m_i_served, m_d_served;
  bit m_prev_ib, m_prev_db;
  int m_stall, m_flush, m_ld;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic pipe_ctrl_state_t state_of(input bit iw, input bit dw);
    if (iw && dw) return WAIT_ID;
    if (iw) return WAIT_I;
    if (dw) return WAIT_D;
    return RUN;
  endfunction

  // per-cycle reference check
  always @(negedge clk) begin
    bit ib, db, frz, br, ld;
    bit e_front, e_back, e_flush, e_zero;
    if (chk_en) begin
      if (!rst_n) begin
        m_i_served = 1'b0; m_d_served = 1'b0;
        m_prev_ib = 1'b0;  m_prev_db = 1'b0;
        m_stall = 0; m_flush = 0; m_ld = 0;
      end
      ib  = rst_n && bus.imem_req_i && !bus.imem_resp_i && !m_i_served;
      db  = rst_n && bus.dmem_req_i && !bus.dmem_resp_i && !m_d_served;
      frz = ib || db;
      br  = rst_n && bus.br_mispredict_i;
      ld  = rst_n && bus.ld_use_stall_i;
      e_back  = !frz;
      e_front = !frz && (br || !ld);
      e_flush = !frz && br;
      e_zero  = !frz && (br || ld);
      cmp("pc_we",     bus.IF_PC_write_o,  e_front);
      cmp("ifid_we",   bus.IF_ID_write_o,  e_front);
      cmp("idex_we",   bus.ID_EX_write_o,  e_back);
      cmp("exmem_we",  bus.EX_MEM_write_o, e_back);
      cmp("memwb_we",  bus.MEM_WB_write_o, e_back);
      cmp("ifid_fl",   bus.IF_ID_flush_o,  e_flush);
      cmp("idex_fl",   bus.ID_EX_flush_o,  e_flush);
      cmp("mux_sel",   bus.ID_controlmux_sel_o, e_zero);
      cmp("state",     bus.state_o, state_of(m_prev_ib, m_prev_db));
`ifdef PIPE_CTRL_PERF_EN
      cmp("stall_cnt", stall_c, sat(m_stall));
      cmp("flush_cnt", flush_c, sat(m_flush));
      cmp("lduse_cnt", ld_c,    sat(m_ld));
`endif
      if (rst_n) begin
        if (frz) begin
          m_stall++;
          m_i_served = m_i_served || (bus.imem_req_i && bus.imem_resp_i);
          m_d_served = m_d_served || (bus.dmem_req_i && bus.dmem_resp_i);
        end else begin
          m_i_served = 1'b0;
          m_d_served = 1'b0;
          if (br) m_flush++;
          else if (ld) m_ld++;
        end
        m_prev_ib = ib;
        m_prev_db = db;
      end
    end
  end

  task automatic cyc(input bit rst, input bit ir, input bit irs, input bit dr, input bit drs,
                     input bit ld, input bit br);
    @(posedge clk);
    #1;
    rst_n               = rst;
    bus.imem_req_i      = ir;
    bus.imem_resp_i     = irs;
    bus.dmem_req_i      = dr;
    bus.dmem_resp_i     = drs;
    bus.ld_use_stall_i  = ld;
    bus.br_mispredict_i = br;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.imem_req_i = 1'b0; bus.imem_resp_i = 1'b0;
    bus.dmem_req_i = 1'b0; bus.dmem_resp_i = 1'b0;
    bus.ld_use_stall_i = 1'b0; bus.br_mispredict_i = 1'b0;
    chk_en = 1'b1;

    // reset with a fetch pending: still a run cycle
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("rst_state", bus.state_o, RUN);
    cmp("rst_pc_we", bus.IF_PC_write_o, 1'b1);
    cmp("rst_memwb", bus.MEM_WB_write_o, 1'b1);
`ifdef PIPE_CTRL_PERF_EN
    cmp("rst_stall", stall_c, 4'd0);
`endif
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("post_rst_pc", bus.IF_PC_write_o, 1'b0);
    cmp("post_rst_wb", bus.MEM_WB_write_o, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("post_rst_st", bus.state_o, WAIT_I);

    // overlapping waits: fetch done on cycle 2, data done on cycle 5
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("ovl_c1_pc", bus.IF_PC_write_o, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("ovl_c2_st", bus.state_o, WAIT_ID);
    cmp("ovl_c2_wb", bus.MEM_WB_write_o, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("ovl_c3_st", bus.state_o, WAIT_D);
    cmp("ovl_c3_pc", bus.IF_PC_write_o, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("ovl_c4_pc", bus.IF_PC_write_o, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cmp("ovl_c5_pc", bus.IF_PC_write_o, 1'b1);
    cmp("ovl_c5_wb", bus.MEM_WB_write_o, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("ovl_c6_pc", bus.IF_PC_write_o, 1'b0);
    cmp("ovl_c6_st", bus.state_o, RUN);
`ifdef PIPE_CTRL_PERF_EN
    cmp("ovl_stall", stall_c, 4'd4);
`endif

    // load-use with no memory stall
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cmp("lu_pc",   bus.IF_PC_write_o, 1'b0);
    cmp("lu_ifid", bus.IF_ID_write_o, 1'b0);
    cmp("lu_idex", bus.ID_EX_write_o, 1'b1);
    cmp("lu_mux",  bus.ID_controlmux_sel_o, zero);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
    cmp("lu_cnt", ld_c, 4'd1);
`endif

    // mispredict beats load-use
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cmp("mp_pc",    bus.IF_PC_write_o, 1'b1);
    cmp("mp_ifdfl", bus.IF_ID_flush_o, 1'b1);
    cmp("mp_idxfl", bus.ID_EX_flush_o, 1'b1);
    cmp("mp_mux",   bus.ID_controlmux_sel_o, zero);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
    cmp("mp_flcnt", flush_c, 4'd1);
    cmp("mp_lucnt", ld_c, 4'd0);
`endif

    // mispredict held across a 3-cycle data wait
    do_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      cmp("mpd_hold_fl", bus.IF_ID_flush_o, 1'b0);
      cmp("mpd_hold_we", bus.EX_MEM_write_o, 1'b0);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    cmp("mpd_adv_fl", bus.ID_EX_flush_o, 1'b1);
    cmp("mpd_adv_pc", bus.IF_PC_write_o, 1'b1);

    // counter saturation over 20 freeze cycles
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
    cmp("sat_stall", stall_c, 4'd15);
`endif

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) >= 2),
          ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 40),
          ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 40),
          ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 15));
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
